// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if: ID-stage instruction fields in, pipeline control/hazard signals out
//   master: datapath side (drives IF/ID fields and ex_zero, consumes control)
//   slave : pipe_control_unit
interface pipe_control_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 3
);
    logic                  instr_valid;
    logic [5:0]            opcode;
    logic [5:0]            func;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ex_zero;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic [1:0]            pc_sel;
    logic                  illegal_instr;
    logic [ALU_CTRL_W-1:0] ex_alu_operation;
    logic                  ex_alu_src;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  mem_read;
    logic                  mem_write;
    logic                  wb_reg_write;
    logic                  wb_data_src;
    logic [REG_ADDR_W-1:0] wb_wr_addr;

    modport master (
        output instr_valid, opcode, func, rs, rt, rd, ex_zero,
        input  pc_write, ifid_write, ifid_flush, pc_sel, illegal_instr,
               ex_alu_operation, ex_alu_src, fwd_a, fwd_b,
               mem_read, mem_write, wb_reg_write, wb_data_src, wb_wr_addr
    );

    modport slave (
        input  instr_valid, opcode, func, rs, rt, rd, ex_zero,
        output pc_write, ifid_write, ifid_flush, pc_sel, illegal_instr,
               ex_alu_operation, ex_alu_src, fwd_a, fwd_b,
               mem_read, mem_write, wb_reg_write, wb_data_src, wb_wr_addr
    );
endinterface

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: 5-stage pipeline controller (decode, ID/EX-EX/MEM-MEM/WB control, hazards, redirect, forwarding)
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_control_unit_if.slave (IF/ID fields, ex_zero in; stall/flush/pc_sel/fwd/stage controls out)
//   PIPE_FORWARD_EN defined: forwarding unit present, only load-use stalls;
//   undefined: fwd_* tied to 00, stall on any EX/MEM producer of a used ID source
module pipe_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 3
) (
    input logic               clk,
    input logic               rst_n,
    pipe_control_unit_if.slave bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] F_NOP   = 6'b000000;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  wb_alu;
        logic                  alu_src;
        logic                  is_beq;
        logic                  is_bne;
        logic [ALU_CTRL_W-1:0] alu_op;
        logic [REG_ADDR_W-1:0] dest;
`ifdef PIPE_FORWARD_EN
        logic                  use_rs;
        logic                  use_rt;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
`endif
    } ex_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  wb_alu;
        logic [REG_ADDR_W-1:0] dest;
    } mem_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  wb_alu;
        logic [REG_ADDR_W-1:0] dest;
    } wb_t;

    ex_t  ex_q, ex_d, dec;
    mem_t mem_q, mem_d;
    wb_t  wb_q, wb_d;

    logic                  r_ok, imm, wr, id_jump, illegal, id_use_rs, id_use_rt;
    logic [ALU_CTRL_W-1:0] r_alu;
    logic [REG_ADDR_W-1:0] dst;
    logic                  uses_ex, uses_mem, br_taken, stall, jump;
    logic [1:0]            fwd_a, fwd_b;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (bus.func)
            F_ADD:   r_alu = ALU_ADD;
            F_SUB:   r_alu = ALU_SUB;
            F_AND:   r_alu = ALU_AND;
            F_OR:    r_alu = ALU_OR;
            F_SLT:   r_alu = ALU_SLT;
            default: r_ok = 1'b0;
        endcase
    end

    // Undecodable and NOP encodings leave the bundle all-zero, i.e. a bubble.
    always_comb begin
        dec       = '0;
        imm       = 1'b0;
        wr        = 1'b0;
        dst       = '0;
        id_jump   = 1'b0;
        illegal   = 1'b0;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        case (bus.opcode)
            OP_R: begin
                if (r_ok) begin
                    dec.alu_op = r_alu;
                    dec.wb_alu = 1'b1;
                    id_use_rs  = 1'b1;
                    id_use_rt  = 1'b1;
                    wr         = 1'b1;
                    dst        = bus.rd;
                end else begin
                    illegal = bus.func != F_NOP;
                end
            end
            OP_LW: begin
                dec.alu_op   = ALU_ADD;
                dec.alu_src  = 1'b1;
                dec.mem_read = 1'b1;
                id_use_rs    = 1'b1;
                wr           = 1'b1;
                dst          = bus.rt;
            end
            OP_SW: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                id_use_rs     = 1'b1;
                id_use_rt     = 1'b1;
            end
            OP_ADDI: begin dec.alu_op = ALU_ADD; imm = 1'b1; end
            OP_ANDI: begin dec.alu_op = ALU_AND; imm = 1'b1; end
            OP_ORI:  begin dec.alu_op = ALU_OR;  imm = 1'b1; end
            OP_SLTI: begin dec.alu_op = ALU_SLT; imm = 1'b1; end
            OP_BEQ: begin
                dec.alu_op = ALU_SUB;
                dec.is_beq = 1'b1;
                id_use_rs  = 1'b1;
                id_use_rt  = 1'b1;
            end
            OP_BNE: begin
                dec.alu_op = ALU_SUB;
                dec.is_bne = 1'b1;
                id_use_rs  = 1'b1;
                id_use_rt  = 1'b1;
            end
            OP_J:    id_jump = 1'b1;
            default: illegal = 1'b1;
        endcase
        if (imm) begin
            dec.alu_src = 1'b1;
            dec.wb_alu  = 1'b1;
            id_use_rs   = 1'b1;
            wr          = 1'b1;
            dst         = bus.rt;
        end
        dec.dest      = wr ? dst : '0;
        dec.reg_write = wr && dst != '0;
        if (!bus.instr_valid) begin
            dec       = '0;
            id_jump   = 1'b0;
            illegal   = 1'b0;
            id_use_rs = 1'b0;
            id_use_rt = 1'b0;
        end
`ifdef PIPE_FORWARD_EN
        dec.use_rs = id_use_rs;
        dec.use_rt = id_use_rt;
        dec.rs     = bus.rs;
        dec.rt     = bus.rt;
`endif
    end

    assign uses_ex  = (id_use_rs && bus.rs == ex_q.dest) || (id_use_rt && bus.rt == ex_q.dest);
    assign uses_mem = (id_use_rs && bus.rs == mem_q.dest) || (id_use_rt && bus.rt == mem_q.dest);
    assign br_taken = (ex_q.is_beq && bus.ex_zero) || (ex_q.is_bne && !bus.ex_zero);

`ifdef PIPE_FORWARD_EN
    // lw dest is checked directly: a load to $0 has reg_write cleared but still reads memory.
    assign stall = ex_q.mem_read && ex_q.dest != '0 && uses_ex;
    // MEM-stage producer is newer than WB-stage, so it wins; reg_write already implies dest != 0.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_q.use_rs)
            fwd_a = (mem_q.reg_write && mem_q.dest == ex_q.rs) ? 2'b10 :
                    (wb_q.reg_write && wb_q.dest == ex_q.rs)   ? 2'b01 : 2'b00;
        if (ex_q.use_rt)
            fwd_b = (mem_q.reg_write && mem_q.dest == ex_q.rt) ? 2'b10 :
                    (wb_q.reg_write && wb_q.dest == ex_q.rt)   ? 2'b01 : 2'b00;
    end
`else
    assign stall = (ex_q.reg_write && uses_ex) || (mem_q.reg_write && uses_mem);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign jump = id_jump && !br_taken && !stall;

    // A taken branch squashes the stalled ID instruction, so the stall is moot.
    assign ex_d  = (br_taken || stall) ? '0 : dec;
    assign mem_d = '{reg_write: ex_q.reg_write, mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                     wb_alu: ex_q.wb_alu, dest: ex_q.dest};
    assign wb_d  = '{reg_write: mem_q.reg_write, wb_alu: mem_q.wb_alu, dest: mem_q.dest};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.pc_write         = br_taken || !stall;
    assign bus.ifid_write       = br_taken || !stall;
    assign bus.ifid_flush       = br_taken || jump;
    assign bus.pc_sel           = br_taken ? 2'b01 : jump ? 2'b10 : 2'b00;
    assign bus.illegal_instr    = illegal;
    assign bus.ex_alu_operation = ex_q.alu_op;
    assign bus.ex_alu_src       = ex_q.alu_src;
    assign bus.fwd_a            = fwd_a;
    assign bus.fwd_b            = fwd_b;
    assign bus.mem_read         = mem_q.mem_read;
    assign bus.mem_write        = mem_q.mem_write;
    assign bus.wb_reg_write     = wb_q.reg_write;
    assign bus.wb_data_src      = wb_q.wb_alu;
    assign bus.wb_wr_addr       = wb_q.dest;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed vector bench for pipe_control_unit
module tb_pipe_control_unit;
    localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] J = 6'h02, ADDI = 6'h08, BAD = 6'h3F, FADD = 6'h20, FSUB = 6'h22;

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       z;
    } in_t;

    typedef struct packed {
        logic       pw;
        logic       iw;
        logic       fl;
        logic [1:0] ps;
        logic       ill;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [2:0] alu;
        logic       src;
        logic       mr;
        logic       mw;
        logic       wrw;
        logic       ws;
        logic [4:0] wad;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nbad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_control_unit_if #(.REG_ADDR_W(5), .ALU_CTRL_W(3)) bus ();

    pipe_control_unit #(.REG_ADDR_W(5), .ALU_CTRL_W(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic in_t in_(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] rs,
                                logic [4:0] rt, logic [4:0] rd, logic z);
        return '{v: v, op: op, fn: fn, rs: rs, rt: rt, rd: rd, z: z};
    endfunction

    function automatic out_t ou(logic pw, logic iw, logic fl, logic [1:0] ps, logic ill,
                                logic [1:0] fa, logic [1:0] fb, logic [2:0] alu, logic src,
                                logic mr, logic mw, logic wrw, logic ws, logic [4:0] wad);
        return '{pw: pw, iw: iw, fl: fl, ps: ps, ill: ill, fa: fa, fb: fb, alu: alu, src: src,
                 mr: mr, mw: mw, wrw: wrw, ws: ws, wad: wad};
    endfunction

    function automatic in_t bub(logic [5:0] op, logic z);
        return in_(1'b0, op, 6'h00, 5'd0, 5'd0, 5'd0, z);
    endfunction

    task automatic add(input in_t i, input out_t o);
        vecs.push_back('{i: i, o: o});
    endtask

    task automatic drive(input in_t x);
        bus.instr_valid = x.v;
        bus.opcode      = x.op;
        bus.func        = x.fn;
        bus.rs          = x.rs;
        bus.rt          = x.rt;
        bus.rd          = x.rd;
        bus.ex_zero     = x.z;
    endtask

    task automatic chk(input string nm, input out_t exp);
        out_t act;
        act = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.pc_sel, bus.illegal_instr,
               bus.fwd_a, bus.fwd_b, bus.ex_alu_operation, bus.ex_alu_src, bus.mem_read,
               bus.mem_write, bus.wb_reg_write, bus.wb_data_src, bus.wb_wr_addr};
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %p expected %p", nm, act, exp);
        end
    endtask

    initial begin
        out_t idle;
        idle = ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // lw $2 / beq taken over a pending use of $2 / bne not taken / j / illegal / addi $0 / sw
        add(in_(1, LW, 0, 1, 2, 0, 0),    idle);
        add(in_(1, BEQ, 0, 5, 6, 0, 0),   ou(1, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        add(in_(1, RT, FADD, 2, 4, 3, 1), ou(1, 1, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0));
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        add(in_(1, BNE, 0, 7, 8, 0, 0),   idle);
        add(bub(BAD, 1),                  ou(1, 1, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0));
        add(in_(1, J, 0, 0, 0, 0, 0),     ou(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(bub(J, 0),                    idle);
        add(in_(1, BAD, 0, 0, 0, 0, 0),   ou(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(in_(1, ADDI, 0, 1, 0, 0, 0),  idle);
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        add(bub(BAD, 0),                  idle);
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        add(in_(1, SW, 0, 1, 4, 0, 0),    idle);
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(bub(BAD, 0),                  idle);

        // lw $2; add $3,$2,$4; add $5,$7,$8; sub $6,$5,$5
        add(in_(1, LW, 0, 1, 2, 0, 0),    idle);
        add(in_(1, RT, FADD, 2, 4, 3, 0), ou(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
`ifdef PIPE_FORWARD_EN
        add(in_(1, RT, FADD, 2, 4, 3, 0), ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        add(in_(1, RT, FADD, 7, 8, 5, 0), ou(1, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 0, 2));
        add(in_(1, RT, FSUB, 5, 5, 6, 0), ou(1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 2, 2, 6, 0, 0, 0, 1, 1, 3));
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5));
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6));
`else
        add(in_(1, RT, FADD, 2, 4, 3, 0), ou(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        add(in_(1, RT, FADD, 2, 4, 3, 0), ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        add(in_(1, RT, FADD, 7, 8, 5, 0), ou(1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        add(in_(1, RT, FSUB, 5, 5, 6, 0), ou(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        add(in_(1, RT, FSUB, 5, 5, 6, 0), ou(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
        add(in_(1, RT, FSUB, 5, 5, 6, 0), ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5));
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0));
        add(bub(BAD, 0),                  idle);
        add(bub(BAD, 0),                  ou(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6));
`endif
        add(in_(1, LW, 0, 1, 2, 0, 0),    idle);

        drive(bub(BAD, 0));
        repeat (2) @(negedge clk);
        chk("reset_values", idle);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            @(negedge clk);
            chk($sformatf("vec%0d", k), vecs[k].o);
            @(posedge clk);
            #1;
        end

        // lw now in EX: stall, then asynchronous reset mid-stall
        drive(in_(1, RT, FADD, 2, 4, 3, 0));
        @(negedge clk);
        chk("stall_before_reset", ou(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        #1 rst_n = 1'b0;
        #1 chk("async_reset", idle);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(bub(BAD, 0));
        @(negedge clk);
        chk("post_reset_fetch", ou(1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
